// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
//
// Game-side controller that pairs with the player group. It runs the
// IDLE / RUNNING / OVER game state machine, divides the system clock into
// game ticks, checks for a collision between the player and the current
// obstacle at each tick, and keeps a saturating score of ticks survived.
//
// Ports
//   clk               in   1        system clock
//   reset             in   1        synchronous, active-high reset
//   start_btn         in   1        debounced start button (level)
//   player_position   in   POS_W    player height, 0 = ground
//   jumping           in   1        player is mid-jump
//   ducking           in   1        player is ducking
//   obstacle_valid    in   1        obstacle_x / obstacle_air are meaningful
//   obstacle_x        in   8        obstacle column
//   obstacle_air      in   1        1 = air obstacle, 0 = ground obstacle
//   game_tick         out  1        1-cycle pulse every TICK_DIV cycles while running
//   game_start_pulse  out  1        1-cycle pulse on entry to RUNNING
//   game_over_pulse   out  1        1-cycle pulse on entry to OVER
//   jump_pulse        out  1        1-cycle pulse after a rising edge of jumping while running
//   crash             out  1        high from entry to OVER until the next start
//   score             out  SCORE_W  ticks survived, saturating at all-ones
//   state             out  2        FSM state: 00 IDLE, 01 RUNNING, 10 OVER
//
// There is no valid/ready traffic in this block: every input is a level
// sampled on each clock edge, and every output is a registered level or a
// registered single-cycle pulse.
//
// All outputs come straight from flops. Events are detected combinationally
// in the cycle they occur and the resulting pulses appear one cycle later.
// ---------------------------------------------------------------------------
module game_ctrl #(
  parameter int TICK_DIV   = 16,
  parameter int POS_W      = 6,
  parameter int SCORE_W    = 10,
  parameter int PLAYER_X   = 8,
  parameter int PLAYER_W   = 4,
  parameter int JUMP_CLEAR = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic [POS_W-1:0]   player_position,
  input  logic               jumping,
  input  logic               ducking,
  input  logic               obstacle_valid,
  input  logic [7:0]         obstacle_x,
  input  logic               obstacle_air,
  output logic               game_tick,
  output logic               game_start_pulse,
  output logic               game_over_pulse,
  output logic               jump_pulse,
  output logic               crash,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int                 CNT_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  // Player column window, compared on 9 bits so PLAYER_X+PLAYER_W-1 can
  // exceed 255 without wrapping back into low columns.
  localparam logic [8:0]         COL_LO     = 9'(PLAYER_X);
  localparam logic [8:0]         COL_HI     = 9'(PLAYER_X + PLAYER_W - 1);
  localparam logic [31:0]        CLEAR_H    = 32'(JUMP_CLEAR);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  // -------------------------------------------------------------------------
  // State machine encoding (also the value driven on the state output)
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 crash_q, crash_d;
  logic                 tick_q, tick_d;
  logic                 start_pulse_q, start_pulse_d;
  logic                 over_pulse_q, over_pulse_d;
  logic                 jump_pulse_q, jump_pulse_d;
  logic                 start_btn_q;
  logic                 jumping_q;

  // -------------------------------------------------------------------------
  // Event detection
  // -------------------------------------------------------------------------
  logic start_edge;
  logic jump_edge;
  logic wrap;
  logic in_col;
  logic too_low;
  logic hit;

  assign start_edge = start_btn & ~start_btn_q;
  assign jump_edge  = jumping & ~jumping_q;

  // The tick counter only advances while running, so a wrap can only ever
  // happen in RUNNING; start_edge is only acted on outside RUNNING.
  assign wrap       = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  assign in_col     = ({1'b0, obstacle_x} >= COL_LO) && ({1'b0, obstacle_x} <= COL_HI);
  assign too_low    = 32'(player_position) < CLEAR_H;

  // Air obstacles are dodged by ducking, ground obstacles by being high enough.
  assign hit        = obstacle_valid & in_col & (obstacle_air ? ~ducking : too_low);

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score_d       = score_q;
    crash_d       = crash_q;
    tick_d        = 1'b0;
    start_pulse_d = 1'b0;
    over_pulse_d  = 1'b0;
    jump_pulse_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d       = ST_RUN;
          start_pulse_d = 1'b1;
          score_d       = '0;
          cnt_d         = '0;
          crash_d       = 1'b0;
        end
      end

      ST_RUN: begin
        cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);
        if (wrap) begin
          tick_d = 1'b1;
          if (hit) begin
            // Collision: the over pulse lines up with the tick and the
            // score keeps the value it had before this tick.
            state_d      = ST_OVER;
            over_pulse_d = 1'b1;
            crash_d      = 1'b1;
          end else if (score_q != SCORE_MAX) begin
            score_d = score_q + SCORE_ONE;
          end
        end
        // The game is ending on a hit cycle, so a jump then is not reported.
        jump_pulse_d = jump_edge & ~(wrap & hit);
      end

      ST_OVER: begin
        // Counter frozen, crash and score held until the next start.
        if (start_edge) begin
          state_d       = ST_RUN;
          start_pulse_d = 1'b1;
          score_d       = '0;
          cnt_d         = '0;
          crash_d       = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        score_d = '0;
        cnt_d   = '0;
        crash_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers; reset overrides every pending event.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      score_q       <= '0;
      crash_q       <= 1'b0;
      tick_q        <= 1'b0;
      start_pulse_q <= 1'b0;
      over_pulse_q  <= 1'b0;
      jump_pulse_q  <= 1'b0;
      start_btn_q   <= 1'b0;
      jumping_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_q       <= score_d;
      crash_q       <= crash_d;
      tick_q        <= tick_d;
      start_pulse_q <= start_pulse_d;
      over_pulse_q  <= over_pulse_d;
      jump_pulse_q  <= jump_pulse_d;
      start_btn_q   <= start_btn;
      jumping_q     <= jumping;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign game_tick        = tick_q;
  assign game_start_pulse = start_pulse_q;
  assign game_over_pulse  = over_pulse_q;
  assign jump_pulse       = jump_pulse_q;
  assign crash            = crash_q;
  assign score            = score_q;
  assign state            = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl
//
// Bench for game_ctrl with TICK_DIV = 4 and default geometry. A cycle model
// of the game rules predicts every output after every clock edge; hand
// sequences and a collision table exercise the timing and boundary cases,
// and a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_game_ctrl;

  localparam int T          = 4;
  localparam int POS_W      = 6;
  localparam int SW         = 10;
  localparam int PX         = 8;
  localparam int PW         = 4;
  localparam int JC         = 12;
  localparam int SMAX       = (1 << SW) - 1;
  localparam int OUT_W      = 5 + SW + 2;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset;
  logic             start_btn;
  logic [POS_W-1:0] player_position;
  logic             jumping;
  logic             ducking;
  logic             obstacle_valid;
  logic [7:0]       obstacle_x;
  logic             obstacle_air;
  logic             game_tick;
  logic             game_start_pulse;
  logic             game_over_pulse;
  logic             jump_pulse;
  logic             crash;
  logic [SW-1:0]    score;
  logic [1:0]       state;

  always #5 clk = ~clk;

  game_ctrl #(
    .TICK_DIV(T), .POS_W(POS_W), .SCORE_W(SW),
    .PLAYER_X(PX), .PLAYER_W(PW), .JUMP_CLEAR(JC)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn),
    .player_position(player_position), .jumping(jumping), .ducking(ducking),
    .obstacle_valid(obstacle_valid), .obstacle_x(obstacle_x), .obstacle_air(obstacle_air),
    .game_tick(game_tick), .game_start_pulse(game_start_pulse),
    .game_over_pulse(game_over_pulse), .jump_pulse(jump_pulse),
    .crash(crash), .score(score), .state(state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: game rules in terms of "cycles since the game started".
  // A tick falls at the end of every T-th cycle of play; the collision rule
  // is the plain column/height/duck test.
  // -------------------------------------------------------------------------
  int m_mode  = 0;   // 0 idle, 1 running, 2 over
  int m_age   = 0;   // cycles since the start pulse cycle
  int m_score = 0;
  int m_crash = 0;
  int m_prev_start = 0;
  int m_prev_jump  = 0;

  logic [OUT_W-1:0] exp_q[$];

  function automatic bit model_hit(input bit v, input int x, input bit air,
                                   input bit duck, input int pos);
    return v && (x >= PX) && (x < PX + PW) && (air ? !duck : (pos < JC));
  endfunction

  always @(posedge clk) begin : model
    int mode, age, sc, cr;
    bit tk, gs, go, jp, se, je, wr, h;
    mode = m_mode; age = m_age; sc = m_score; cr = m_crash;
    tk = 0; gs = 0; go = 0; jp = 0;
    if (reset) begin
      mode = 0; age = 0; sc = 0; cr = 0;
      m_prev_start <= 0;
      m_prev_jump  <= 0;
    end else begin
      se = start_btn && !m_prev_start;
      je = jumping && !m_prev_jump;
      if (mode == 1) begin
        wr = (age % T) == (T - 1);
        h  = model_hit(obstacle_valid, int'(obstacle_x), obstacle_air, ducking,
                       int'(player_position));
        if (wr) begin
          tk = 1;
          if (h) begin
            mode = 2; go = 1; cr = 1;
          end else begin
            sc = (sc < SMAX) ? sc + 1 : SMAX;
          end
        end
        jp  = je && !(wr && h);
        age = age + 1;
      end else if (se) begin
        mode = 1; age = 0; sc = 0; cr = 0; gs = 1;
      end
      m_prev_start <= int'(start_btn);
      m_prev_jump  <= int'(jumping);
    end
    m_mode  <= mode;
    m_age   <= age;
    m_score <= sc;
    m_crash <= cr;
    exp_q.push_back({tk, gs, go, jp, cr[0], sc[SW-1:0], mode[1:0]});
  end

  // Scoreboard: compare every cycle's outputs against the model, mid-cycle.
  always @(negedge clk) begin
    logic [OUT_W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {game_tick, game_start_pulse, game_over_pulse, jump_pulse, crash, score, state};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs: got tick=%b gsp=%b gop=%b jp=%b crash=%b score=%0d state=%0d expected tick=%b gsp=%b gop=%b jp=%b crash=%b score=%0d state=%0d at %0t",
                 a[OUT_W-1], a[OUT_W-2], a[OUT_W-3], a[OUT_W-4], a[OUT_W-5], a[SW+1:2], a[1:0],
                 e[OUT_W-1], e[OUT_W-2], e[OUT_W-3], e[OUT_W-4], e[OUT_W-5], e[SW+1:2], e[1:0], $time);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge only)
  // -------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  // Returns the number of cycles until game_tick is seen, or 0 on timeout.
  task automatic wait_tick(input int budget, output int gap);
    gap = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (game_tick) begin
        gap = i;
        break;
      end
    end
  endtask

  task automatic set_obstacle(input bit v, input int x, input bit air,
                              input bit duck, input int pos);
    obstacle_valid  = v;
    obstacle_x      = 8'(x);
    obstacle_air    = air;
    ducking         = duck;
    player_position = POS_W'(pos);
  endtask

  // -------------------------------------------------------------------------
  // Collision table
  // -------------------------------------------------------------------------
  typedef struct {
    bit v;
    int x;
    bit air;
    bit duck;
    int pos;
    bit exp_hit;
  } hit_vec_t;

  hit_vec_t tbl[10];

  initial begin
    int gap;

    tbl[0] = '{1, 9,   0, 0, 3,  1};  // ground obstacle, player on the ground
    tbl[1] = '{1, 9,   0, 0, 12, 0};  // exactly at the clearing height
    tbl[2] = '{1, 11,  1, 1, 0,  0};  // air obstacle, ducking
    tbl[3] = '{1, 11,  1, 0, 0,  1};  // air obstacle, standing
    tbl[4] = '{0, 9,   0, 0, 0,  0};  // obstacle not valid
    tbl[5] = '{1, 7,   0, 0, 0,  0};  // one column left of the player
    tbl[6] = '{1, 8,   0, 0, 0,  1};  // leftmost player column
    tbl[7] = '{1, 12,  0, 0, 0,  0};  // one column right of the player
    tbl[8] = '{1, 11,  0, 0, 11, 1};  // one below the clearing height
    tbl[9] = '{1, 255, 1, 0, 0,  0};  // far column, no wrap into window

    reset = 1'b1; start_btn = 1'b0; jumping = 1'b0;
    set_obstacle(0, 0, 0, 0, 0);

    // Reset and idle
    cycles(3);
    check("reset_state", 32'(state), 0);
    check("reset_score", 32'(score), 0);
    check("reset_crash", 32'(crash), 0);
    reset = 1'b0;
    jumping = 1'b1;            // a jump in IDLE must not pulse
    cycles(10);
    jumping = 1'b0;
    cycles(10);

    // Start timing and the first three ticks
    press_start();
    check("start_pulse", 32'(game_start_pulse), 1);
    check("start_state", 32'(state), 1);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(20, gap);
      check("tick_gap", 32'(gap), 4);
      check("tick_score", 32'(score), 32'(k));
    end

    // Collision table: one tick per record
    for (int i = 0; i < 10; i++) begin
      if (state != 2'd1) press_start();
      set_obstacle(tbl[i].v, tbl[i].x, tbl[i].air, tbl[i].duck, tbl[i].pos);
      wait_tick(20, gap);
      check("tbl_tick_seen", 32'(gap != 0), 1);
      check("tbl_crash", 32'(crash), 32'(tbl[i].exp_hit));
      check("tbl_over_pulse", 32'(game_over_pulse), 32'(tbl[i].exp_hit));
      check("tbl_state", 32'(state), tbl[i].exp_hit ? 2 : 1);
    end

    // Jump edge while running gives exactly one pulse
    set_obstacle(0, 0, 0, 0, 0);
    if (state != 2'd1) press_start();
    jumping = 1'b1;
    @(negedge clk);
    check("jump_pulse", 32'(jump_pulse), 1);
    @(negedge clk);
    check("jump_pulse_once", 32'(jump_pulse), 0);
    jumping = 1'b0;

    // Score saturation
    cycles((SMAX + 20) * T);
    check("score_saturated", 32'(score), 32'(SMAX));
    check("sat_state", 32'(state), 1);

    // Crash with a saturated score, then a jump in OVER
    set_obstacle(1, 9, 0, 0, 0);
    wait_tick(20, gap);
    check("over_state", 32'(state), 2);
    check("over_score_held", 32'(score), 32'(SMAX));
    jumping = 1'b1;
    @(negedge clk);
    check("no_jump_in_over", 32'(jump_pulse), 0);
    jumping = 1'b0;
    cycles(8);
    check("over_no_tick", 32'(game_tick), 0);

    // Restart from OVER
    press_start();
    check("restart_pulse", 32'(game_start_pulse), 1);
    check("restart_crash", 32'(crash), 0);
    check("restart_score", 32'(score), 0);
    set_obstacle(0, 0, 0, 0, 0);

    // Reset in the middle of a game
    cycles(9);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_state", 32'(state), 0);
    check("midreset_score", 32'(score), 0);
    check("midreset_pulses",
          32'({game_tick, game_start_pulse, game_over_pulse, jump_pulse, crash}), 0);
    reset = 1'b0;
    cycles(2);

    // Randomized phase, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 5) == 0) jumping = ~jumping;
      set_obstacle($urandom_range(0, 1), $urandom_range(5, 14), $urandom_range(0, 1),
                   ($urandom_range(0, 2) == 0), $urandom_range(0, 20));
      @(negedge clk);
    end
    reset = 1'b0;
    cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
